// File: rtl/conv_fetch_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : conv_fetch_scheduler_pkg                               |
// | Description : Shared state encodings and default widths for the      |
// |               convolution fetch scheduler.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package conv_fetch_scheduler_pkg;

  localparam int DEF_WORD_WIDTH = 128;  // 8 lanes x 16 bit
  localparam int DEF_NUM_PIXELS = 8;    // pixels per fetch / column-group stride

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_tap_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : conv_tap_counter                                       |
// | Description : Nested kc/kr/col_group/out_row loop counters with      |
// |               multiplier-free row/column offset accumulators.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module conv_tap_counter
  import conv_fetch_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 8,
  parameter int NUM_PIXELS = DEF_NUM_PIXELS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_clear,
  input  logic                  i_advance,
  input  logic [ADDR_WIDTH-1:0] i_img_width,
  input  logic [DIM_WIDTH-1:0]  i_out_rows,
  input  logic [DIM_WIDTH-1:0]  i_col_groups,
  input  logic [DIM_WIDTH-1:0]  i_kernel_size,
  output logic [ADDR_WIDTH-1:0] o_row_offset,
  output logic [ADDR_WIDTH-1:0] o_col_offset,
  output logic                  o_first_tap,
  output logic                  o_last_tap,
  output logic                  o_sweep_last
);

  localparam logic [DIM_WIDTH-1:0]  c_dim_one  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_stride   = ADDR_WIDTH'(NUM_PIXELS);

  // Latched configuration; the "last" values are stored pre-decremented
  logic [ADDR_WIDTH-1:0] r_img_width;
  logic [DIM_WIDTH-1:0]  r_k_last, r_cg_last, r_row_last;
  // Loop counters
  logic [DIM_WIDTH-1:0]  r_kc, r_kr, r_cg, r_row;
  // Offset accumulators
  logic [ADDR_WIDTH-1:0] r_col_base, r_col_off, r_row_base, r_tap_row_off;

  logic w_kc_last, w_kr_last, w_cg_last, w_row_last;

  assign w_kc_last  = (r_kc  == r_k_last);
  assign w_kr_last  = (r_kr  == r_k_last);
  assign w_cg_last  = (r_cg  == r_cg_last);
  assign w_row_last = (r_row == r_row_last);

  assign o_row_offset = r_tap_row_off;
  assign o_col_offset = r_col_off;
  assign o_first_tap  = (r_kc == '0) && (r_kr == '0);
  assign o_last_tap   = w_kc_last && w_kr_last;
  assign o_sweep_last = w_kc_last && w_kr_last && w_cg_last && w_row_last;

  // Latch config on clear, then step the innermost-first loop nest on advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_img_width   <= '0;
      r_k_last      <= '0;
      r_cg_last     <= '0;
      r_row_last    <= '0;
      r_kc          <= '0;
      r_kr          <= '0;
      r_cg          <= '0;
      r_row         <= '0;
      r_col_base    <= '0;
      r_col_off     <= '0;
      r_row_base    <= '0;
      r_tap_row_off <= '0;
    end else if (i_clear) begin
      r_img_width   <= i_img_width;
      r_k_last      <= i_kernel_size - c_dim_one;
      r_cg_last     <= i_col_groups - c_dim_one;
      r_row_last    <= i_out_rows - c_dim_one;
      r_kc          <= '0;
      r_kr          <= '0;
      r_cg          <= '0;
      r_row         <= '0;
      r_col_base    <= '0;
      r_col_off     <= '0;
      r_row_base    <= '0;
      r_tap_row_off <= '0;
    end else if (i_advance) begin
      if (!w_kc_last) begin
        r_kc      <= r_kc + c_dim_one;
        r_col_off <= r_col_off + c_addr_one;
      end else begin
        r_kc <= '0;
        if (!w_kr_last) begin
          r_kr          <= r_kr + c_dim_one;
          r_col_off     <= r_col_base;
          r_tap_row_off <= r_tap_row_off + r_img_width;
        end else begin
          r_kr <= '0;
          if (!w_cg_last) begin
            r_cg          <= r_cg + c_dim_one;
            r_col_base    <= r_col_base + c_stride;
            r_col_off     <= r_col_base + c_stride;
            r_tap_row_off <= r_row_base;
          end else begin
            r_cg          <= '0;
            r_row         <= r_row + c_dim_one;
            r_col_base    <= '0;
            r_col_off     <= '0;
            r_row_base    <= r_row_base + r_img_width;
            r_tap_row_off <= r_row_base + r_img_width;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_fetch_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : conv_fetch_scheduler                                   |
// | Description : Sequences per-tap fetches over a convolution sweep and |
// |               forwards fetched words to the PE array with tap flags. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module conv_fetch_scheduler
  import conv_fetch_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 8,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int NUM_PIXELS = DEF_NUM_PIXELS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_img_width,
  input  logic [DIM_WIDTH-1:0]  i_out_rows,
  input  logic [DIM_WIDTH-1:0]  i_col_groups,
  input  logic [DIM_WIDTH-1:0]  i_kernel_size,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fetch_en,
  output logic                  o_fetch_start,
  output logic [ADDR_WIDTH-1:0] o_fetch_base_addr,
  output logic [ADDR_WIDTH-1:0] o_fetch_row_offset,
  output logic [ADDR_WIDTH-1:0] o_fetch_col_offset,
  input  logic                  i_fetch_done,
  input  logic [WORD_WIDTH-1:0] i_fetch_word,
  output logic                  o_pe_valid,
  input  logic                  i_pe_ready,
  output logic [WORD_WIDTH-1:0] o_pe_word,
  output logic                  o_pe_first_tap,
  output logic                  o_pe_last_tap
);

  state_t                r_state;
  logic                  r_busy, r_done, r_fetch_start, r_pe_valid;
  logic                  r_first_tap, r_last_tap;
  logic [WORD_WIDTH-1:0] r_pe_word;
  logic [ADDR_WIDTH-1:0] r_base_addr;

  logic w_accept, w_advance, w_cfg_zero;
  logic w_first_tap, w_last_tap, w_sweep_last;

  // A start is only taken from a fully idle scheduler; abort always wins
  assign w_accept   = (r_state == S_IDLE) && i_start && !r_busy && !i_abort;
  assign w_advance  = (r_state == S_HOLD) && i_pe_ready && !i_abort;
  assign w_cfg_zero = (i_out_rows == '0) || (i_col_groups == '0) || (i_kernel_size == '0);

  conv_tap_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH),
    .NUM_PIXELS (NUM_PIXELS)
  ) u_tap_counter (
    .clk           (clk),
    .rstn          (rstn),
    .i_clear       (w_accept),
    .i_advance     (w_advance),
    .i_img_width   (i_img_width),
    .i_out_rows    (i_out_rows),
    .i_col_groups  (i_col_groups),
    .i_kernel_size (i_kernel_size),
    .o_row_offset  (o_fetch_row_offset),
    .o_col_offset  (o_fetch_col_offset),
    .o_first_tap   (w_first_tap),
    .o_last_tap    (w_last_tap),
    .o_sweep_last  (w_sweep_last)
  );

  // Sweep FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fetch_start <= 1'b0;
      r_pe_valid    <= 1'b0;
      r_pe_word     <= '0;
      r_first_tap   <= 1'b0;
      r_last_tap    <= 1'b0;
      r_base_addr   <= '0;
    end else begin
      r_fetch_start <= 1'b0;
      r_done        <= 1'b0;
      // busy drops once the done pulse has been presented
      if (r_done) r_busy <= 1'b0;
      if (i_abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_pe_valid  <= 1'b0;
        r_first_tap <= 1'b0;
        r_last_tap  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_base_addr <= i_base_addr;
              r_busy      <= 1'b1;
              if (w_cfg_zero) begin
                r_state <= S_DONE;
              end else begin
                r_state       <= S_ISSUE;
                r_fetch_start <= 1'b1;
              end
            end
          end
          S_ISSUE: r_state <= S_WAIT;
          S_WAIT: begin
            if (i_fetch_done) begin
              r_pe_word   <= i_fetch_word;
              r_pe_valid  <= 1'b1;
              r_first_tap <= w_first_tap;
              r_last_tap  <= w_last_tap;
              r_state     <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (i_pe_ready) begin
              r_pe_valid <= 1'b0;
              if (w_sweep_last) begin
                r_state <= S_DONE;
              end else begin
                r_state       <= S_ISSUE;
                r_fetch_start <= 1'b1;
              end
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_fetch_en        = r_busy;
  assign o_fetch_start     = r_fetch_start;
  assign o_fetch_base_addr = r_base_addr;
  assign o_pe_valid        = r_pe_valid;
  assign o_pe_word         = r_pe_word;
  assign o_pe_first_tap    = r_first_tap;
  assign o_pe_last_tap     = r_last_tap;

endmodule
`default_nettype wire

// File: tb/tb_conv_fetch_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_conv_fetch_scheduler                                |
// | Description : Scoreboard bench for conv_fetch_scheduler with a       |
// |               fixed-latency fetch unit model.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_conv_fetch_scheduler;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int WW  = 128;
  localparam int LAT = 4;

  typedef struct {
    logic [AW-1:0] ro;
    logic [AW-1:0] co;
    logic          first;
    logic          last;
  } tap_t;

  typedef struct {
    logic [WW-1:0] w;
    logic          first;
    logic          last;
  } pe_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start, abort, fetch_done, pe_ready;
  logic [AW-1:0] base_addr, img_width;
  logic [DW-1:0] out_rows, col_groups, kernel_size;
  logic          busy, done, fetch_en, fetch_start, pe_valid, first_tap, last_tap;
  logic [AW-1:0] fb_addr, row_off, col_off;
  logic [WW-1:0] fetch_word, pe_word;

  tap_t q_tap[$];
  pe_t  q_pe[$];
  tap_t cur_tap;
  pe_t  cur_pe;

  int n_chk = 0, n_pass = 0;
  int n_fs, n_hs, n_done, n_busy, exp_n;
  int cyc = 0, s_cyc, done_cyc, last_hs_cyc;
  logic [AW-1:0] exp_base;
  logic outstanding = 1'b0;
  logic g_drop = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_fetch_scheduler dut (
    .clk                (clk),
    .rstn               (rstn),
    .i_start            (start),
    .i_abort            (abort),
    .i_base_addr        (base_addr),
    .i_img_width        (img_width),
    .i_out_rows         (out_rows),
    .i_col_groups       (col_groups),
    .i_kernel_size      (kernel_size),
    .o_busy             (busy),
    .o_done             (done),
    .o_fetch_en         (fetch_en),
    .o_fetch_start      (fetch_start),
    .o_fetch_base_addr  (fb_addr),
    .o_fetch_row_offset (row_off),
    .o_fetch_col_offset (col_off),
    .i_fetch_done       (fetch_done),
    .i_fetch_word       (fetch_word),
    .o_pe_valid         (pe_valid),
    .i_pe_ready         (pe_ready),
    .o_pe_word          (pe_word),
    .o_pe_first_tap     (first_tap),
    .o_pe_last_tap      (last_tap)
  );

  task automatic chk(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
  endtask

  // Fetch unit model: checks each issued tap, answers LAT cycles later
  initial begin
    fetch_done = 1'b0;
    fetch_word = '0;
    forever begin
      @(negedge clk);
      if (fetch_start) begin
        if (q_tap.size() == 0) begin
          chk("fetch_unexpected", 1, 0);
          cur_tap = '{ro: '0, co: '0, first: 1'b0, last: 1'b0};
        end else begin
          cur_tap = q_tap.pop_front();
          chk("row_offset", row_off, cur_tap.ro);
          chk("col_offset", col_off, cur_tap.co);
          chk("base_addr", fb_addr, exp_base);
        end
        repeat (LAT) @(posedge clk);
        #1;
        fetch_word = {$urandom, $urandom, $urandom, $urandom};
        fetch_done = 1'b1;
        if (!g_drop) q_pe.push_back('{w: fetch_word, first: cur_tap.first, last: cur_tap.last});
        @(posedge clk);
        #1;
        fetch_done = 1'b0;
      end
    end
  end

  // Output monitor: PE handshakes against the scoreboard, fetch ordering, done/busy
  always @(negedge clk) begin
    if (rstn && pe_valid && pe_ready) begin
      n_hs++;
      last_hs_cyc = cyc;
      if (q_pe.size() == 0) chk("pe_unexpected", 1, 0);
      else begin
        cur_pe = q_pe.pop_front();
        chk("pe_word", pe_word, cur_pe.w);
        chk("pe_first_tap", first_tap, cur_pe.first);
        chk("pe_last_tap", last_tap, cur_pe.last);
      end
    end
    if (fetch_start) begin
      chk("fetch_no_overlap", outstanding, 0);
      outstanding = 1'b1;
      n_fs++;
    end
    if (fetch_done) outstanding = 1'b0;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) n_busy++;
  end

  task automatic launch(input logic [AW-1:0] base, input logic [AW-1:0] imgw,
                        input int rows, input int cg, input int k);
    tap_t t;
    q_tap.delete();
    q_pe.delete();
    exp_n = rows * cg * k * k;
    for (int r = 0; r < rows; r++)
      for (int g = 0; g < cg; g++)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            t.ro    = AW'((r + kr) * int'(imgw));
            t.co    = AW'(g * 8 + kc);
            t.first = (kr == 0) && (kc == 0);
            t.last  = (kr == k - 1) && (kc == k - 1);
            q_tap.push_back(t);
          end
    n_fs = 0; n_hs = 0; n_done = 0; n_busy = 0;
    exp_base = base;
    @(posedge clk);
    #1;
    base_addr   = base;
    img_width   = imgw;
    out_rows    = DW'(rows);
    col_groups  = DW'(cg);
    kernel_size = DW'(k);
    start       = 1'b1;
    s_cyc       = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input logic [AW-1:0] base, input logic [AW-1:0] imgw,
                           input int rows, input int cg, input int k);
    int t = 0;
    launch(base, imgw, rows, cg, k);
    while (n_done == 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", (n_done != 0), 1);
    repeat (4) @(negedge clk);
    chk("done_pulses", n_done, 1);
    chk("fetch_count", n_fs, exp_n);
    chk("handshakes", n_hs, exp_n);
    chk("taps_left", q_tap.size(), 0);
    chk("pe_left", q_pe.size(), 0);
    chk("busy_after", busy, 0);
    if (exp_n == 0) begin
      chk("zero_done_lat", done_cyc - s_cyc, 2);
      chk("zero_busy_cyc", n_busy, 2);
    end else begin
      chk("done_after_last_hs", (done_cyc > last_hs_cyc), 1);
    end
  endtask

  task automatic stall_once(input int after_hs);
    int t = 0;
    int fs0;
    logic [WW-1:0] w;
    logic f, l;
    while (n_hs < after_hs && t < 5000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    pe_ready = 1'b0;
    t = 0;
    while (!pe_valid && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", pe_valid, 1);
    w = pe_word; f = first_tap; l = last_tap; fs0 = n_fs;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", pe_valid, 1);
      chk("bp_word", pe_word, w);
      chk("bp_first", first_tap, f);
      chk("bp_last", last_tap, l);
    end
    chk("bp_no_fetch", n_fs, fs0);
    @(posedge clk);
    #1;
    pe_ready = 1'b1;
  endtask

  initial begin
    int t;
    start = 1'b0; abort = 1'b0; pe_ready = 1'b1;
    base_addr = '0; img_width = '0; out_rows = '0; col_groups = '0; kernel_size = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_fetch_start", fetch_start, 0);
    chk("rst_pe_valid", pe_valid, 0);
    chk("rst_row_off", row_off, 0);
    chk("rst_col_off", col_off, 0);
    chk("rst_pe_word", pe_word, 0);
    chk("rst_flags", {first_tap, last_tap}, 0);

    // Basic 2x1 sweep with 3x3 kernel
    run_sweep(12'h100, 12'd32, 2, 1, 3);
    // Two column groups
    run_sweep(12'h100, 12'd32, 2, 2, 3);
    // Backpressure on the 4th tap
    fork
      run_sweep(12'h0A0, 12'd32, 2, 1, 3);
      stall_once(3);
    join
    // Degenerate sizes
    run_sweep(12'h100, 12'd32, 2, 1, 0);
    run_sweep(12'h100, 12'd32, 0, 1, 3);

    // start together with abort in IDLE is dropped
    n_fs = 0; n_done = 0;
    @(posedge clk);
    #1;
    out_rows = 8'd2; col_groups = 8'd1; kernel_size = 8'd3;
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("sa_busy", busy, 0);
    chk("sa_fetch", n_fs, 0);
    chk("sa_done", n_done, 0);

    // Abort while waiting on fetch 5, late fetch_done must be ignored
    launch(12'h100, 12'd32, 2, 1, 3);
    t = 0;
    while (n_fs < 5 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("ab_fetch5", n_fs, 5);
    @(posedge clk);
    #1;
    abort = 1'b1;
    g_drop = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    chk("ab_pe_valid", pe_valid, 0);
    chk("ab_fetch_start", fetch_start, 0);
    chk("ab_done", done, 0);
    repeat (8) @(negedge clk);
    chk("ab_late_valid", pe_valid, 0);
    chk("ab_no_done", n_done, 0);
    chk("ab_no_fetch", n_fs, 5);
    chk("ab_busy_late", busy, 0);
    g_drop = 1'b0;
    run_sweep(12'h100, 12'd32, 2, 1, 3);

    // Row offset wraps modulo 4096
    run_sweep(12'h000, 12'hF00, 3, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
